runway_allocator: RTL and testbench
===================================

Name: runway_allocator

Overview:
Parametrised successor to the two-runway picker. It arbitrates landing and takeoff requests across NUM_RUNWAYS runways using a valid/ready handshake and round-robin selection. Each runway has its own occupancy timer. The block publishes a per-runway status code and a busy count. It sits between the request queue and the tower signal/display logic.

Parameters:
NUM_RUNWAYS, 4, number of runways; legal range 2..16
LAND_CYCLES, 12, occupancy cycles for a landing; must be >= 1
TAKEOFF_CYCLES, 8, occupancy cycles for a takeoff; must be >= 1
IDX_W, $clog2(NUM_RUNWAYS), runway index width (derived, not overridden)
CNT_W, $clog2(max(LAND_CYCLES,TAKEOFF_CYCLES)+1), timer width (derived)

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_kind  in  1  0 = landing, 1 = takeoff
req_ready  out  1  request can be accepted this cycle
emerg  in  1  emergency level; while high, takeoffs are blocked
runway_close  in  NUM_RUNWAYS  per-runway closure, level
grant_valid  out  1  one-cycle pulse, grant issued
grant_runway  out  IDX_W  granted runway index, valid with grant_valid
grant_kind  out  1  echo of the accepted req_kind
signal  out  2*NUM_RUNWAYS  per-runway status: 00 free, 01 landing, 10 takeoff, 11 closed
busy_count  out  IDX_W+1  number of runways with a nonzero timer

Behaviour:
- One clock; reset is asynchronous and active-high. While rst is high: all timers = 0, RR pointer = 0, grant_valid = 0, grant_runway = 0, grant_kind = 0, busy_count = 0, and signal is 00 for every runway that is not closed.
- Eligible runway: timer == 0 and runway_close bit = 0. Eligibility uses registered timer state only.
- req_ready (combinational) = at least one runway eligible AND NOT (emerg AND req_kind = 1). Note that req_ready depends on req_kind.
- Accept: req_valid AND req_ready at a posedge.
- Selection: pick the first eligible runway scanning from the RR pointer upward, wrapping from NUM_RUNWAYS-1 to 0. The RR pointer then becomes (granted index + 1) mod NUM_RUNWAYS. The pointer is unchanged when nothing is accepted.
- Latency: accept at edge t produces all of the following in the cycle after t, for exactly one cycle of grant_valid:
  - grant_valid = 1, with grant_runway and grant_kind valid;
  - the granted runway's timer loaded with LAND_CYCLES or TAKEOFF_CYCLES;
  - signal shows 01 or 10 for that runway.
- Timer: decrements by 1 per cycle while nonzero. It holds the current kind for status reporting. A runway loaded at edge t is eligible again after edge t + LOAD value (busy for exactly LOAD cycles).
- Expiry and request in the same cycle: a timer going 1 -> 0 at edge t does not make the runway grantable for a request presented in the cycle before t. No combinational bypass.
- Closure:
  - signal = 11 whenever the close bit is high, overriding the occupied code.
  - A runway closed mid-occupancy keeps counting down and is never granted while closed.
  - Reopening takes effect combinationally on eligibility.
- emerg: landings are still accepted. A takeoff held with req_valid = 1 simply stalls (req_ready = 0) until emerg falls.
- All runways ineligible: req_ready = 0 and no state change.
- busy_count counts timers != 0, regardless of closure. Registered, so it is consistent with signal.
- Reset asserted mid-occupancy: timers clear immediately and no grant pulse is produced.

Decomposition:
- atc_pkg:
  - request-kind constants KIND_LAND = 1'b0 and KIND_TAKEOFF = 1'b1;
  - status codes SIG_FREE, SIG_LAND, SIG_TAKEOFF, SIG_CLOSED;
  - a 2-bit status type.
- Sub-module runway_timer: one per runway, generated.
  - Inputs: clk, rst, load, load_kind, load_value, close.
  - Outputs: busy, status.
  - Countdown and status encoding live here.
- The top level holds the RR pointer, selection, handshake, grant register and busy-count adder.

Test Plan:
1. Reset, then a landing request with all runways open -> grant_valid at the next cycle with runway 0; signal[1:0] = 01 for exactly 12 cycles, then 00; busy_count goes 1 -> 0.
2. Five back-to-back landings, req_valid held high -> grants to runways 0, 1, 2, 3; the fifth stalls with req_ready = 0 until runway 0 frees (12 cycles after its grant), then is granted runway 0.
3. runway_close = 4'b0010 and the pointer at 1 -> a landing is granted runway 2; signal[3:2] = 11; reopening makes runway 1 eligible the same cycle.
4. emerg = 1 with a takeoff request -> req_ready = 0 and no grant; a landing is still granted; emerg falls -> the takeoff is granted next cycle with grant_kind = 1 and 8 cycles of occupancy.
5. Pointer wrap: grants to runway 3, then a request with only runways 0 and 2 free -> runway 0 is chosen; pointer = 1.
6. rst asserted asynchronously mid-occupancy with 3 runways busy -> all timers are 0, busy_count = 0, grant_valid = 0 immediately without waiting for a clock; the first request after release goes to runway 0.

Source files
------------

// File: rtl/atc_pkg.sv
// Shared encodings for the runway allocator: request kinds and per-runway status codes.
package atc_pkg;

    typedef logic [1:0] status_t;

    localparam logic KIND_LAND    = 1'b0;
    localparam logic KIND_TAKEOFF = 1'b1;

    localparam status_t SIG_FREE    = 2'b00;
    localparam status_t SIG_LAND    = 2'b01;
    localparam status_t SIG_TAKEOFF = 2'b10;
    localparam status_t SIG_CLOSED  = 2'b11;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/runway_allocator_if.sv
// Request/grant handshake between the request queue (master) and the allocator (slave).
interface runway_allocator_if #(
    parameter int NUM_RUNWAYS = 4
);
    localparam int IDX_W = $clog2(NUM_RUNWAYS);

    logic             req_valid;
    logic             req_kind;
    logic             req_ready;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_runway;
    logic             grant_kind;

    modport master (
        output req_valid, req_kind,
        input  req_ready, grant_valid, grant_runway, grant_kind
    );

    modport slave (
        input  req_valid, req_kind,
        output req_ready, grant_valid, grant_runway, grant_kind
    );
endinterface

// File: rtl/runway_timer.sv
// Per-runway occupancy countdown plus status encoding; closure overrides the occupied code.
module runway_timer
    import atc_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             load_kind,
    input  logic [CNT_W-1:0] load_value,
    input  logic             close,
    output logic             busy,
    output status_t          status
);
    logic [CNT_W-1:0] cnt;
    logic             kind;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            kind <= KIND_LAND;
        end else if (load) begin
            cnt  <= load_value;
            kind <= load_kind;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);

    always_comb begin
        status = SIG_FREE;
        if (close)
            status = SIG_CLOSED;
        else if (busy)
            status = (kind == KIND_TAKEOFF) ? SIG_TAKEOFF : SIG_LAND;
    end
endmodule

// File: rtl/runway_allocator.sv
// Round-robin runway allocator: valid/ready request intake, one-cycle grant pulse,
// per-runway occupancy timers, status codes and busy count.
module runway_allocator
    import atc_pkg::*;
#(
    parameter  int NUM_RUNWAYS    = 4,
    parameter  int LAND_CYCLES    = 12,
    parameter  int TAKEOFF_CYCLES = 8,
    localparam int IDX_W          = $clog2(NUM_RUNWAYS),
    localparam int CNT_W          = $clog2(max_int(LAND_CYCLES, TAKEOFF_CYCLES) + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    runway_allocator_if.slave        bus,
    input  logic                     emerg,
    input  logic [NUM_RUNWAYS-1:0]   runway_close,
    output logic [2*NUM_RUNWAYS-1:0] signal,
    output logic [IDX_W:0]           busy_count
);
    localparam logic [CNT_W-1:0] LAND_V    = CNT_W'(LAND_CYCLES);
    localparam logic [CNT_W-1:0] TAKEOFF_V = CNT_W'(TAKEOFF_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_RUNWAYS - 1);

    logic [NUM_RUNWAYS-1:0] busy;
    logic [NUM_RUNWAYS-1:0] elig;
    logic [NUM_RUNWAYS-1:0] load;
    logic [IDX_W-1:0]       ptr;
    logic [IDX_W-1:0]       sel_idx;
    logic [IDX_W-1:0]       cand;
    logic                   sel_found;
    logic                   accept;
    logic [CNT_W-1:0]       load_value;

    // Eligibility sees only registered timer state; reopening a runway is combinational.
    assign elig = ~busy & ~runway_close;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_RUNWAYS; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_RUNWAYS);
            if (!sel_found && elig[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign bus.req_ready = sel_found && !(emerg && bus.req_kind == KIND_TAKEOFF);
    assign accept        = bus.req_valid && bus.req_ready;
    assign load_value    = (bus.req_kind == KIND_TAKEOFF) ? TAKEOFF_V : LAND_V;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr              <= '0;
            bus.grant_valid  <= 1'b0;
            bus.grant_runway <= '0;
            bus.grant_kind   <= KIND_LAND;
        end else begin
            bus.grant_valid <= accept;
            if (accept) begin
                ptr              <= (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
                bus.grant_runway <= sel_idx;
                bus.grant_kind   <= bus.req_kind;
            end
        end
    end

    for (genvar g = 0; g < NUM_RUNWAYS; g++) begin : g_rw
        assign load[g] = accept && (sel_idx == IDX_W'(g));

        runway_timer #(.CNT_W(CNT_W)) u_timer (
            .clk        (clk),
            .rst        (rst),
            .load       (load[g]),
            .load_kind  (bus.req_kind),
            .load_value (load_value),
            .close      (runway_close[g]),
            .busy       (busy[g]),
            .status     (signal[2*g +: 2])
        );
    end

    // Sum of timer flops, so it tracks signal in the same cycle.
    always_comb begin
        busy_count = '0;
        for (int i = 0; i < NUM_RUNWAYS; i++)
            busy_count = busy_count + (IDX_W+1)'(busy[i]);
    end
endmodule

// File: tb/tb_runway_allocator.sv
// Directed bench for runway_allocator; grants are checked by a scoreboard monitor.
module tb_runway_allocator;
    import atc_pkg::*;

    localparam int N = 4;

    typedef struct {
        int   runway;
        logic kind;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         emerg = 1'b0;
    logic [N-1:0] runway_close = '0;
    logic [2*N-1:0] sig;
    logic [2:0]   busy_count;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    runway_allocator_if #(.NUM_RUNWAYS(N)) ifc ();

    runway_allocator #(.NUM_RUNWAYS(N), .LAND_CYCLES(12), .TAKEOFF_CYCLES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (ifc.slave),
        .emerg        (emerg),
        .runway_close (runway_close),
        .signal       (sig),
        .busy_count   (busy_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor: every grant pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && ifc.grant_valid) begin
            if (sb.size() == 0) begin
                fail("unexpected_grant");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("grant_runway", int'(ifc.grant_runway), e.runway);
                chk("grant_kind", int'(ifc.grant_kind), int'(e.kind));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        ifc.req_valid = 1'b0;
        ifc.req_kind  = KIND_LAND;
        emerg = 1'b0;
        runway_close = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_ready(output int stalls);
        stalls = 0;
        @(negedge clk);
        while (!ifc.req_ready && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        if (!ifc.req_ready) fail("ready_timeout");
    endtask

    // Present one request, wait for acceptance, expect the grant the following cycle.
    task automatic issue(input logic kind, input int exp_rw);
        int s;
        ifc.req_kind  = kind;
        ifc.req_valid = 1'b1;
        wait_ready(s);
        sb.push_back('{exp_rw, kind});
        @(posedge clk); #1;
        ifc.req_valid = 1'b0;
        chk("grant_latency", int'(ifc.grant_valid), 1);
    endtask

    task automatic occ(input int idx, input logic [1:0] code, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("occ_code", int'(sig[2*idx +: 2]), int'(code));
        end
        @(negedge clk);
        chk("occ_free", int'(sig[2*idx +: 2]), int'(SIG_FREE));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int s;
        ifc.req_valid = 1'b0;
        ifc.req_kind  = KIND_LAND;
        #2;
        chk("rst_grant_valid", int'(ifc.grant_valid), 0);
        chk("rst_busy_count", int'(busy_count), 0);
        chk("rst_signal", int'(sig), 0);
        chk("rst_grant_runway", int'(ifc.grant_runway), 0);

        // 1: single landing, 12 cycles of occupancy on runway 0
        do_reset();
        issue(KIND_LAND, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("t1_sig", int'(sig[1:0]), int'(SIG_LAND));
            chk("t1_busy", int'(busy_count), 1);
        end
        @(negedge clk);
        chk("t1_sig_end", int'(sig[1:0]), int'(SIG_FREE));
        chk("t1_busy_end", int'(busy_count), 0);

        // 2: five held landings, fifth stalls until runway 0 frees
        do_reset();
        ifc.req_kind  = KIND_LAND;
        ifc.req_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            wait_ready(s);
            if (n == 4) chk("t2_stall_cycles", s, 8);
            sb.push_back('{n % 4, KIND_LAND});
            @(posedge clk); #1;
            if (n == 3) begin
                @(negedge clk);
                chk("t2_busy4", int'(busy_count), 4);
                chk("t2_ready_low", int'(ifc.req_ready), 0);
            end
        end
        ifc.req_valid = 1'b0;
        chk("t2_grant_latency", int'(ifc.grant_valid), 1);

        // 3: closure skips runway 1; reopening is visible the same cycle
        do_reset();
        issue(KIND_LAND, 0);
        runway_close = 4'b0010;
        issue(KIND_LAND, 2);
        @(negedge clk);
        chk("t3_closed_code", int'(sig[3:2]), int'(SIG_CLOSED));
        chk("t3_r2_land", int'(sig[5:4]), int'(SIG_LAND));
        runway_close = 4'b1010;
        ifc.req_kind  = KIND_LAND;
        ifc.req_valid = 1'b1;
        @(negedge clk);
        chk("t3_ready_all_blocked", int'(ifc.req_ready), 0);
        runway_close = 4'b1000;
        #1;
        chk("t3_reopen_ready", int'(ifc.req_ready), 1);
        sb.push_back('{1, KIND_LAND});
        @(posedge clk); #1;
        ifc.req_valid = 1'b0;
        chk("t3_grant_latency", int'(ifc.grant_valid), 1);

        // 4: emergency blocks takeoffs but not landings
        do_reset();
        emerg = 1'b1;
        ifc.req_kind  = KIND_TAKEOFF;
        ifc.req_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t4_to_blocked", int'(ifc.req_ready), 0);
        end
        ifc.req_kind = KIND_LAND;
        #1;
        chk("t4_land_ready", int'(ifc.req_ready), 1);
        sb.push_back('{0, KIND_LAND});
        @(posedge clk); #1;
        chk("t4_land_grant", int'(ifc.grant_valid), 1);
        ifc.req_kind = KIND_TAKEOFF;
        repeat (3) begin
            @(negedge clk);
            chk("t4_to_stall", int'(ifc.req_ready), 0);
        end
        emerg = 1'b0;
        #1;
        chk("t4_to_ready", int'(ifc.req_ready), 1);
        sb.push_back('{1, KIND_TAKEOFF});
        @(posedge clk); #1;
        ifc.req_valid = 1'b0;
        chk("t4_to_grant", int'(ifc.grant_valid), 1);
        occ(1, SIG_TAKEOFF, 8);

        // 5: pointer wrap from runway 3 back to 0
        do_reset();
        runway_close = 4'b0111;
        issue(KIND_LAND, 3);
        runway_close = 4'b0010;
        issue(KIND_LAND, 0);
        runway_close = 4'b0000;
        issue(KIND_LAND, 1);

        // 6: asynchronous reset mid-occupancy
        do_reset();
        issue(KIND_LAND, 0);
        issue(KIND_LAND, 1);
        ifc.req_valid = 1'b1;
        wait_ready(s);
        sb.push_back('{2, KIND_LAND});
        @(posedge clk); #1;
        ifc.req_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("t6_grant_cleared", int'(ifc.grant_valid), 0);
        chk("t6_busy_cleared", int'(busy_count), 0);
        chk("t6_sig_cleared", int'(sig), 0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        issue(KIND_LAND, 0);

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
